fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage ARM pipeline.
- Owns the fetch PC and drives a handshaked instruction-memory port with at most one request outstanding.
- Delivers {pc, instruction, valid} into the IF/ID stage register.
- Stalls under hazard-unit control, and flushes and redirects when a branch resolves taken in the MEM stage (branch & zero).

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns fetch PC, one-outstanding imem handshake, feeds IF/ID.
// Latency: 2 cycles from issue to IF/ID valid. A one-entry skid absorbs a response that arrives while IF/ID is stalled.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INS_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic              ifid_valid,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [INS_W-1:0]  ifid_ins,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0]    ifid_ins_q, ifid_ins_d;
    logic                skid_vld_q, skid_vld_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic [INS_W-1:0]    skid_ins_q, skid_ins_d;
    logic [CNT_W-1:0]    flush_count_q, flush_count_d;

    logic req;
    logic hs;
    logic accept;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_ins_d    = ifid_ins_q;
        skid_vld_d    = skid_vld_q;
        skid_pc_d     = skid_pc_q;
        skid_ins_d    = skid_ins_q;
        flush_count_d = flush_count_q;
        req           = 1'b0;

        // IF/ID can take a new entry when it is empty or moving forward.
        accept = !ifid_valid_q || !stall;

        case (state_q)
            ISSUE:   req = !skid_vld_q && !redirect_valid;
            WAIT:    req = imem_rvalid && !skid_vld_q && accept && !redirect_valid;
            default: req = 1'b0;
        endcase
        hs = req && imem_ready;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & ~ADDR_W'(3);
            ifid_valid_d = 1'b0;
            skid_vld_d   = 1'b0;
            if (flush_count_q != '1) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end
            case (state_q)
                WAIT, DROP: state_d = imem_rvalid ? ISSUE : DROP;
                default:    state_d = ISSUE;
            endcase
        end else begin
            if (hs) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
                state_d       = WAIT;
            end

            if (state_q == DROP && imem_rvalid) begin
                state_d = ISSUE;
            end

            if (state_q == WAIT && imem_rvalid) begin
                if (accept) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = inflight_pc_q;
                    ifid_ins_d   = imem_rdata;
                end else begin
                    skid_vld_d = 1'b1;
                    skid_pc_d  = inflight_pc_q;
                    skid_ins_d = imem_rdata;
                end
                if (!hs) begin
                    state_d = ISSUE;
                end
            end else if (!stall) begin
                if (skid_vld_q) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_ins_d   = skid_ins_q;
                    skid_vld_d   = 1'b0;
                end else begin
                    ifid_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ISSUE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_pc_q     <= '0;
            ifid_ins_q    <= '0;
            skid_vld_q    <= 1'b0;
            skid_pc_q     <= '0;
            skid_ins_q    <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_ins_q    <= ifid_ins_d;
            skid_vld_q    <= skid_vld_d;
            skid_pc_q     <= skid_pc_d;
            skid_ins_q    <= skid_ins_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = fetch_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_ins    = ifid_ins_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order memory model of configurable latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_ins;
    logic [15:0] flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: returns pc>>2 mem_lat cycles after a handshake; stray injects an unsolicited response.
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_pc = '0;
    logic        stray = 1'b0;
    logic [31:0] stray_dat = '0;

    assign imem_rvalid = (mem_busy && mem_cnt == 0) || stray;
    assign imem_rdata  = stray ? stray_dat : 32'(mem_pc >> 2);

    always @(posedge clk) begin
        if (imem_req && imem_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_pc   <= imem_addr;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_ins       (ifid_ins),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b0;
        stray          = 1'b0;
        mem_lat        = 1;
        repeat (3) nxt();
        reset = 1'b0;
    endtask

    task automatic chk_ifid(input string tag, input logic [63:0] pc, input logic [63:0] ins);
        check({tag, "_vld"}, 64'(ifid_valid), 64'd1);
        check({tag, "_pc"}, ifid_pc, pc);
        check({tag, "_ins"}, 64'(ifid_ins), ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Cold start and stall
        do_reset();
        imem_ready = 1'b1;
        #1;
        check("rst_vld", 64'(ifid_valid), 64'd0);
        check("rst_pc", ifid_pc, 64'd0);
        check("rst_ins", 64'(ifid_ins), 64'd0);
        check("rst_flush", 64'(flush_count), 64'd0);
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, 64'd0);
        nxt();
        check("c1_addr", imem_addr, 64'd4);
        check("c1_vld", 64'(ifid_valid), 64'd0);
        for (int k = 2; k <= 4; k++) begin
            nxt();
            chk_ifid("cold", 64'(4 * (k - 2)), 64'(k - 2));
            check("cold_addr", imem_addr, 64'(4 * k));
        end
        stall = 1'b1;
        #1;
        check("stall_req0", 64'(imem_req), 64'd0);
        for (int k = 0; k < 2; k++) begin
            nxt();
            chk_ifid("stall_hold", 64'd8, 64'd2);
            check("stall_req", 64'(imem_req), 64'd0);
        end
        nxt();
        stall = 1'b0;
        #1;
        chk_ifid("rel_hold", 64'd8, 64'd2);
        check("rel_req", 64'(imem_req), 64'd0);
        nxt();
        chk_ifid("rel_skid", 64'd12, 64'd3);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            nxt();
            if (ifid_valid) found = 1'b1;
        end
        check("rel_next_found", 64'(found), 64'd1);
        chk_ifid("rel_next", 64'd16, 64'd4);

        // Redirect while a 3-cycle request is in flight
        do_reset();
        imem_ready = 1'b1;
        repeat (8) nxt();
        chk_ifid("pre_rd", 64'h18, 64'h6);
        check("pre_rd_addr", imem_addr, 64'h20);
        mem_lat = 3;
        nxt();
        chk_ifid("rd_c9", 64'h1c, 64'h7);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        #1;
        check("rd_req", 64'(imem_req), 64'd0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        check("drop_vld", 64'(ifid_valid), 64'd0);
        check("drop_addr", imem_addr, 64'h100);
        check("drop_flush", 64'(flush_count), 64'd1);
        check("drop_req", 64'(imem_req), 64'd0);
        nxt();
        check("drop_rv_req", 64'(imem_req), 64'd0);
        nxt();
        check("refetch_req", 64'(imem_req), 64'd1);
        check("refetch_addr", imem_addr, 64'h100);
        for (int k = 0; k < 4; k++) begin
            check("refetch_bubble", 64'(ifid_valid), 64'd0);
            nxt();
        end
        chk_ifid("refetch", 64'h100, 64'h40);

        // Redirect with stall, full skid and a same-cycle stray response
        do_reset();
        imem_ready = 1'b1;
        repeat (4) nxt();
        stall = 1'b1;
        nxt();
        chk_ifid("rs_hold", 64'd8, 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        stray          = 1'b1;
        stray_dat      = 32'hdeadbeef;
        #1;
        check("rs_req", 64'(imem_req), 64'd0);
        nxt();
        redirect_valid = 1'b0;
        stray          = 1'b0;
        #1;
        check("rs_vld", 64'(ifid_valid), 64'd0);
        check("rs_req_issue", 64'(imem_req), 64'd1);
        check("rs_addr", imem_addr, 64'h200);
        nxt();
        check("rs_bubble", 64'(ifid_valid), 64'd0);
        nxt();
        chk_ifid("rs_fill", 64'h200, 64'h80);
        check("rs_flush", 64'(flush_count), 64'd1);
        stall = 1'b0;

        // Back-pressure from memory
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_req", 64'(imem_req), 64'd1);
            check("bp_addr", imem_addr, 64'd0);
            check("bp_vld", 64'(ifid_valid), 64'd0);
            nxt();
        end
        imem_ready = 1'b1;
        nxt();
        check("bp_addr4", imem_addr, 64'd4);
        nxt();
        chk_ifid("bp_first", 64'd0, 64'd0);

        // Reset in the middle of a fetch, then a stray response in ISSUE
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        nxt();
        redirect_valid = 1'b0;
        mem_lat        = 3;
        #1;
        check("mr_req", 64'(imem_req), 64'd1);
        check("mr_addr", imem_addr, 64'h40);
        check("mr_flush", 64'(flush_count), 64'd1);
        nxt();
        check("mr_wait_addr", imem_addr, 64'h44);
        reset      = 1'b1;
        imem_ready = 1'b0;
        nxt();
        reset = 1'b0;
        check("mr_rst_addr", imem_addr, 64'd0);
        check("mr_rst_vld", 64'(ifid_valid), 64'd0);
        check("mr_rst_flush", 64'(flush_count), 64'd0);
        nxt();
        nxt();
        check("mr_stray_vld", 64'(ifid_valid), 64'd0);
        check("mr_stray_addr", imem_addr, 64'd0);
        imem_ready = 1'b1;
        mem_lat    = 1;
        nxt();
        nxt();
        chk_ifid("mr_first", 64'd0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
